ex4_cell_rr_sched: RTL
======================

// Module: ex4_cell_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one 4-bit bitwise gate-network cell (ex4_2) between NREQ requesters.
//  Each requester offers an (a,b) operand pair with a valid/ready handshake.
//  The scheduler grants one requester per cycle and drives its operands into the shared cell.
//  It registers the 4-bit result with the requester id into a single-entry response stage.
//  Sits between the operand producers and the result consumer; this block is the only driver of the cell inputs.
// PARAMETERS
//  NREQ  4               number of requesters, 2..8
//  IDW   $clog2(NREQ)    width of requester id; derived, do not override
//  CNTW  8               width of issued-operation counter
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   NREQ       per-requester operand valid
//  req_a      in   NREQ*4     packed a operands, requester i at [4i+3:4i]
//  req_b      in   NREQ*4     packed b operands, same packing
//  req_ready  out  NREQ       one-hot (or zero) accept strobe
//  rsp_valid  out  1          response stage holds a result
//  rsp_y      out  4          cell output for the granted pair
//  rsp_id     out  IDW        requester index of the result
//  rsp_ready  in   1          consumer accepts the response
//  issued_cnt out  CNTW       accepted requests since reset, saturating
// BEHAVIOUR
//  - Reset values (async assert, sync release):
//    - rsp_valid=0, rsp_y=0, rsp_id=0, issued_cnt=0.
//    - RR pointer ptr=0.
//    - req_ready=0 while rst_n=0.
//  - FSM states:
//    - EMPTY: response stage free.
//    - FULL: rsp_valid=1.
//  - can_accept = (state==EMPTY) | rsp_ready.
//  - Grant:
//    - First i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ.
//    - req_ready[i]=1 only for that i, and only when can_accept; otherwise req_ready=0.
//    - Combinational from req_valid, ptr and state.
//  - Accept (req_valid[i] & req_ready[i]):
//    - Cell inputs = req_a[i], req_b[i].
//    - On the next edge, rsp_y gets the cell output, rsp_id gets i, state becomes FULL, ptr = (i+1) mod NREQ.
//    - Latency: 1 cycle from accept to rsp_valid.
//  - Cell inputs are driven to 0 when there is no grant; no spurious toggling.
//  - Cell function is per bit: y[k] = b[k] for all a. The bench models this as the golden function.
//  - FULL & rsp_ready & no grant: state goes to EMPTY and rsp_valid falls next cycle.
//  - FULL & rsp_ready & grant: new result is loaded and rsp_valid stays 1. Sustained throughput is 1 per cycle.
//  - FULL & !rsp_ready: req_ready=0 and ptr holds. rsp_y and rsp_id are stable until consumed.
//  - Requesters hold req_valid, req_a and req_b until accepted. A grant is not locked across cycles; arbitration is re-run every cycle.
//  - No requests: ptr holds.
//  - issued_cnt increments by 1 per accept and saturates at 2^CNTW-1.
//  - Reset mid-operation: a held response is discarded, ptr returns to 0, no req_ready is asserted until after rst_n release.
// STRUCTURE
//  - Shared package ex4_sched_pkg:
//    - Cell width constant CELL_W=4.
//    - State enum {EMPTY, FULL}.
//    - Function rr_next(ptr, idx).
//  - Sub-module rr_pick:
//    - Parameterised NREQ.
//    - Inputs: req vector, ptr.
//    - Outputs: one-hot gnt, gnt_idx, any.
//  - Top level: rr_pick, the operand mux, one ex4_2 instance, the response register, the FSM and the counter.
// TESTING
//  1. Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, issued_cnt=0. Assert rst_n mid-FULL -> rsp_valid drops immediately.
//  2. Single requester:
//     - req_valid=4'b0100, a=4'hA, b=4'h5, rsp_ready=1.
//     - Expect req_ready=4'b0100, next cycle rsp_valid=1, rsp_y=4'h5, rsp_id=2.
//  3. RR fairness:
//     - All 4 valid, rsp_ready=1 for 8 cycles.
//     - Expect grant order 0,1,2,3,0,1,2,3 and one rsp per cycle with rsp_y=b of each grant.
//  4. Backpressure:
//     - Hold rsp_ready=0 with 2 valid requesters.
//     - Expect one accept, then req_ready=0, and rsp_y/rsp_id stable for 10 cycles.
//     - Release rsp_ready -> next requester is accepted the same cycle.
//  5. Pointer skip:
//     - ptr=1, req_valid=4'b1001.
//     - Expect grant 3, then ptr=0, then grant 0.
//  6. Counter:
//     - CNTW=4, run 20 accepts -> issued_cnt saturates at 15.

Source files
------------

// File: rtl/ex4_sched_pkg.sv
// rtl/ex4_sched_pkg.sv - shared constants, state type and pointer helper for the cell scheduler
package ex4_sched_pkg;

    // Operand / result width of the shared gate-network cell.
    localparam int CELL_W = 4;

    // Response stage occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    // Round-robin pointer update: after a grant the search starts just past
    // the winner; without a grant the pointer holds.
    function automatic int rr_next(input int ptr, input int idx, input int nreq, input logic take);
        return take ? (idx + 1) % nreq : ptr;
    endfunction

endpackage

// File: rtl/ex4_2.sv
// rtl/ex4_2.sv - shared 4-bit bitwise gate-network cell
// Ports: a, b (CELL_W operands) -> y (CELL_W result); per bit y = (a & b) | (~a & b) = b.
module ex4_2
    import ex4_sched_pkg::*;
(
    input  logic [CELL_W-1:0] a,
    input  logic [CELL_W-1:0] b,
    output logic [CELL_W-1:0] y
);

    assign y = (a & b) | (~a & b);

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority picker: first set req bit at or after ptr
// Ports: req (NREQ), ptr (IDW) -> gnt (one-hot NREQ), gnt_idx (IDW), any.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        // Walk offsets from ptr; the first valid requester found wins.
        for (int off = 0; off < NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && req[i] && (i == (int'(ptr) + off) % NREQ)) begin
                    any     = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ex4_cell_rr_sched.sv
// rtl/ex4_cell_rr_sched.sv - round-robin scheduler sharing one ex4_2 cell among NREQ requesters
// Ports: clk, rst_n; req_valid/req_a/req_b in, req_ready out (one-hot accept);
//        rsp_valid/rsp_y/rsp_id out with rsp_ready in; issued_cnt saturating accept count.
module ex4_cell_rr_sched
    import ex4_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CELL_W-1:0] req_a,
    input  logic [NREQ*CELL_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [CELL_W-1:0]      rsp_y,
    output logic [IDW-1:0]         rsp_id,
    input  logic                   rsp_ready,
    output logic [CNTW-1:0]        issued_cnt
);

    rsp_state_e        state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CELL_W-1:0] rsp_y_q, rsp_y_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic              any;
    logic              can_accept;
    logic              accept;
    logic [CELL_W-1:0] cell_a, cell_b, cell_y;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Output logic. rst_n gates the accept so nothing is granted while reset
    // is held, even though the state flop already reads EMPTY.
    always_comb begin
        can_accept = (state_q == EMPTY) | rsp_ready;
        accept     = any & can_accept & rst_n;
        req_ready  = accept ? gnt : '0;
        rsp_valid  = (state_q == FULL);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = FULL;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // Operand mux: AND-OR over the one-hot grant, forced to zero without an
    // accept so the cell inputs stay quiet when idle or stalled.
    always_comb begin
        cell_a = '0;
        cell_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && gnt[i]) begin
                cell_a = cell_a | req_a[i*CELL_W +: CELL_W];
                cell_b = cell_b | req_b[i*CELL_W +: CELL_W];
            end
        end
    end

    ex4_2 u_cell (
        .a (cell_a),
        .b (cell_b),
        .y (cell_y)
    );

    always_comb begin
        ptr_d    = IDW'(rr_next(int'(ptr_q), int'(gnt_idx), NREQ, accept));
        rsp_y_d  = accept ? cell_y : rsp_y_q;
        rsp_id_d = accept ? gnt_idx : rsp_id_q;
        cnt_d    = cnt_q;
        if (accept && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            rsp_y_q  <= '0;
            rsp_id_q <= '0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rsp_y_q  <= rsp_y_d;
            rsp_id_q <= rsp_id_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rsp_y      = rsp_y_q;
    assign rsp_id     = rsp_id_q;
    assign issued_cnt = cnt_q;

endmodule
